ghr_ckpt_ctrl: RTL and testbench

Speculative-history controller for the predictor's global history shift register (GHR). Shifts predicted outcomes into the GHR at predict time and checkpoints the pre-shift history per in-flight branch in a circular FIFO. On an in-order misprediction or pipeline flush, it restores the GHR through the register's reload port. Sits between fetch/predict and branch-resolve logic and is the only driver of the GHR write and reload ports.

---
 rtl/ghr_ckpt_ctrl_pkg.sv | 27 ++
 rtl/ghr_ckpt_fifo.sv | 79 +++++++
 rtl/ghr_ckpt_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ghr_ckpt_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghr_ckpt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ghr_ckpt_ctrl_pkg
// Description : Shared global-history definitions: history width, default
//               checkpoint depth, GHR init value and the checkpoint
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ghr_ckpt_ctrl_pkg;

    // History width shared by every consumer of the global history register.
    localparam int GHR_HIST_W = 14;

    // Default number of in-flight branch checkpoints.
    localparam int GHR_CKPT_DEPTH = 8;

    // Value the GHR itself takes out of reset.
    localparam logic [GHR_HIST_W-1:0] GHR_INIT = 14'h1ABC;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } ckpt_state_t;

endpackage : ghr_ckpt_ctrl_pkg
`default_nettype wire

// File: rtl/ghr_ckpt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ghr_ckpt_fifo
// Description : HIST_W x DEPTH circular buffer holding the pre-shift GHR
//               value of each in-flight branch, oldest at the head.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               push, push_data - append a checkpoint at the tail
//               pop             - retire the head entry
//               clear           - discard all entries (has priority)
//               head_data       - oldest checkpoint
//               count/full/empty- occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module ghr_ckpt_fifo #(
    parameter int HIST_W = 14,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [HIST_W-1:0] push_data,
    input  logic              pop,
    input  logic              clear,
    output logic [HIST_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEPTH);

    logic [HIST_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            // Younger entries are wrong-path: jump the head to the tail.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = (r_count == C_CNT_MAX);
    assign empty     = (r_count == '0);

endmodule : ghr_ckpt_fifo
`default_nettype wire

// File: rtl/ghr_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ghr_ckpt_ctrl
// Description : Speculative GHR controller. Shifts predicted outcomes into
//               the GHR, checkpoints the pre-shift history per in-flight
//               branch and restores the GHR on mispredict or flush.
// Ports       : clk, reset                 - clock, sync active-high reset
//               predict_valid/_taken       - new prediction
//               pred_ready                 - prediction can be accepted
//               resolve_valid/_mispredict/_taken - in-order resolution
//               flush                      - discard all in-flight branches
//               ghr_rd_data                - current GHR value
//               ghr_wr_en/_data            - GHR shift port
//               ghr_re_en/_data            - GHR reload port
//               ckpt_count                 - occupied checkpoint slots
//               recovering                 - reload cycle in progress
//               err_underflow              - sticky resolve-while-empty
// Revision    : 1.0 - initial release
// ============================================================================
module ghr_ckpt_ctrl
    import ghr_ckpt_ctrl_pkg::*;
#(
    parameter int HIST_W = GHR_HIST_W,
    parameter int DEPTH  = GHR_CKPT_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              predict_valid,
    input  logic              predict_taken,
    output logic              pred_ready,
    input  logic              resolve_valid,
    input  logic              resolve_mispredict,
    input  logic              resolve_taken,
    input  logic              flush,
    input  logic [HIST_W-1:0] ghr_rd_data,
    output logic              ghr_wr_en,
    output logic              ghr_wr_data,
    output logic              ghr_re_en,
    output logic [HIST_W-1:0] ghr_re_data,
    output logic [CNT_W-1:0]  ckpt_count,
    output logic              recovering,
    output logic              err_underflow
);

    ckpt_state_t       r_state;
    ckpt_state_t       w_next_state;
    logic [HIST_W-1:0] r_rec_data;
    logic [HIST_W-1:0] w_rec_next;
    logic              r_err_underflow;

    logic              w_pred_ready;
    logic              w_mispred;
    logic              w_kill;
    logic              w_acc;
    logic              w_pop;
    logic              w_clear;
    logic              w_set_err;

    logic [HIST_W-1:0] w_head_data;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    ghr_ckpt_fifo #(
        .HIST_W (HIST_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_acc),
        .push_data (ghr_rd_data),
        .pop       (w_pop),
        .clear     (w_clear),
        .head_data (w_head_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // State register and recovery/error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_rec_data      <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rec_data <= w_rec_next;
            if (w_set_err) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state, FIFO control and GHR port gating
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_rec_next   = r_rec_data;
        w_pred_ready = 1'b0;
        w_mispred    = 1'b0;
        w_kill       = 1'b0;
        w_acc        = 1'b0;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        w_set_err    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Registered count: a same-cycle pop frees no slot yet.
                w_pred_ready = !reset && !w_full;
                w_mispred    = resolve_valid && resolve_mispredict && !w_empty;
                w_kill       = flush || w_mispred;
                w_acc        = predict_valid && w_pred_ready && !w_kill;

                if (w_mispred) begin
                    // Mispredict beats a coincident flush: the restored
                    // history must carry the corrected outcome.
                    w_clear      = 1'b1;
                    w_rec_next   = {w_head_data[HIST_W-2:0], resolve_taken};
                    w_next_state = ST_RECOVER;
                end else if (flush && !w_empty) begin
                    w_clear      = 1'b1;
                    w_rec_next   = w_head_data;
                    w_next_state = ST_RECOVER;
                end else if (resolve_valid && !resolve_mispredict && !w_empty) begin
                    w_pop = 1'b1;
                end

                if (resolve_valid && w_empty) begin
                    w_set_err = 1'b1;
                end
            end

            ST_RECOVER: begin
                // FIFO is already empty; any resolve here is an underflow.
                w_next_state = ST_IDLE;
                if (resolve_valid) begin
                    w_set_err = 1'b1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // The shift port only fires in IDLE and the reload port only in
    // RECOVER, so the two are mutually exclusive by construction.
    assign pred_ready    = w_pred_ready;
    assign ghr_wr_en     = w_acc;
    assign ghr_wr_data   = w_acc && predict_taken;
    assign ghr_re_en     = (r_state == ST_RECOVER) && !reset;
    assign ghr_re_data   = ghr_re_en ? r_rec_data : '0;
    assign ckpt_count    = w_count;
    assign recovering    = (r_state == ST_RECOVER);
    assign err_underflow = r_err_underflow;

endmodule : ghr_ckpt_ctrl
`default_nettype wire

// File: tb/tb_ghr_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ghr_ckpt_ctrl
// Description : Self-checking bench for ghr_ckpt_ctrl. Hosts a GHR register
//               model driven by the DUT's shift/reload ports; expected
//               checkpoints and reload values are queued by the stimulus and
//               reload values are popped when the DUT raises ghr_re_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ghr_ckpt_ctrl;

    localparam int HIST_W = 14;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              predict_valid;
    logic              predict_taken;
    logic              pred_ready;
    logic              resolve_valid;
    logic              resolve_mispredict;
    logic              resolve_taken;
    logic              flush;
    logic [HIST_W-1:0] ghr_q;
    logic              ghr_wr_en;
    logic              ghr_wr_data;
    logic              ghr_re_en;
    logic [HIST_W-1:0] ghr_re_data;
    logic [CNT_W-1:0]  ckpt_count;
    logic              recovering;
    logic              err_underflow;

    logic              force_en;
    logic [HIST_W-1:0] force_val;

    int checks = 0;
    int errors = 0;

    logic [HIST_W-1:0] ck_q[$];      // expected checkpoint contents, oldest first
    logic [HIST_W-1:0] reload_q[$];  // expected reload values
    logic [HIST_W-1:0] m_ghr;        // expected GHR value

    ghr_ckpt_ctrl #(
        .HIST_W (HIST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .predict_valid      (predict_valid),
        .predict_taken      (predict_taken),
        .pred_ready         (pred_ready),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .resolve_taken      (resolve_taken),
        .flush              (flush),
        .ghr_rd_data        (ghr_q),
        .ghr_wr_en          (ghr_wr_en),
        .ghr_wr_data        (ghr_wr_data),
        .ghr_re_en          (ghr_re_en),
        .ghr_re_data        (ghr_re_data),
        .ckpt_count         (ckpt_count),
        .recovering         (recovering),
        .err_underflow      (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GHR register: own reset has priority, then reload, then shift.
    always @(posedge clk) begin
        if (reset)          ghr_q <= 14'h1ABC;
        else if (force_en)  ghr_q <= force_val;
        else if (ghr_re_en) ghr_q <= ghr_re_data;
        else if (ghr_wr_en) ghr_q <= {ghr_q[HIST_W-2:0], ghr_wr_data};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every reload must match the oldest queued value.
    always @(negedge clk) begin
        if (!reset) begin
            chk("wr_re_exclusive", {31'd0, ghr_wr_en & ghr_re_en}, 32'd0);
            if (ghr_re_en === 1'b1) begin
                if (reload_q.size() == 0) chk("reload_unexpected", {31'd0, ghr_re_en}, 32'd0);
                else chk("reload_data", ghr_re_data, reload_q.pop_front());
            end
        end
    end

    task automatic set_in(input logic pv, input logic pt, input logic rv,
                          input logic rm, input logic rt, input logic fl);
        predict_valid      = pv;
        predict_taken      = pt;
        resolve_valid      = rv;
        resolve_mispredict = rm;
        resolve_taken      = rt;
        flush              = fl;
    endtask

    // Advance one clock and return to idle inputs shortly after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0);
        #1;
    endtask

    // Present a prediction that is expected to be accepted.
    task automatic predict(input logic t);
        set_in(1, t, 0, 0, 0, 0);
        #1;
        chk("pred_wr_en", {31'd0, ghr_wr_en}, 32'd1);
        chk("pred_wr_data", {31'd0, ghr_wr_data}, {31'd0, t});
        ck_q.push_back(m_ghr);
        m_ghr = {m_ghr[HIST_W-2:0], t};
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        force_en  = 1'b0;
        force_val = '0;
        reset     = 1'b1;
        set_in(1, 1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        // Reset values, with a prediction pending to show it is refused.
        chk("rst_pred_ready", {31'd0, pred_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, ghr_wr_en}, 32'd0);
        chk("rst_re_en", {31'd0, ghr_re_en}, 32'd0);
        chk("rst_re_data", ghr_re_data, 32'd0);
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        m_ghr = 14'h1ABC;
        chk("rst_count", ckpt_count, 32'd0);
        chk("rst_recovering", {31'd0, recovering}, 32'd0);
        chk("rst_err", {31'd0, err_underflow}, 32'd0);
        chk("rst_ready_after", {31'd0, pred_ready}, 32'd1);
        chk("rst_ghr", ghr_q, m_ghr);

        // Predict T, N, T.
        predict(1'b1);
        predict(1'b0);
        predict(1'b1);
        chk("tnt_count", ckpt_count, 32'd3);
        chk("tnt_ghr", ghr_q, m_ghr);

        // Mispredict the oldest, actual not-taken.
        set_in(0, 0, 1, 1, 0, 0);
        reload_q.push_back({ck_q[0][HIST_W-2:0], 1'b0});
        m_ghr = {ck_q[0][HIST_W-2:0], 1'b0};
        ck_q.delete();
        cyc();
        chk("mis_re_en", {31'd0, ghr_re_en}, 32'd1);
        chk("mis_re_data", ghr_re_data, 32'h3578);
        chk("mis_recovering", {31'd0, recovering}, 32'd1);
        chk("mis_pred_ready", {31'd0, pred_ready}, 32'd0);
        chk("mis_count", ckpt_count, 32'd0);
        cyc();
        chk("mis_ready_again", {31'd0, pred_ready}, 32'd1);
        chk("mis_re_en_low", {31'd0, ghr_re_en}, 32'd0);
        chk("mis_ghr", ghr_q, m_ghr);

        // Flush with two entries, oldest checkpoint 14'h0F0F.
        force_en  = 1'b1;
        force_val = 14'h0F0F;
        @(posedge clk);
        #1;
        force_en = 1'b0;
        m_ghr    = 14'h0F0F;
        predict(1'b1);
        predict(1'b0);
        chk("fl_count", ckpt_count, 32'd2);
        set_in(0, 0, 0, 0, 0, 1);
        reload_q.push_back(14'h0F0F);
        m_ghr = 14'h0F0F;
        ck_q.delete();
        cyc();
        chk("fl_re_en", {31'd0, ghr_re_en}, 32'd1);
        chk("fl_re_data", ghr_re_data, 32'h0F0F);
        cyc();
        chk("fl_ghr", ghr_q, m_ghr);

        // Flush with nothing in flight: no reload.
        set_in(0, 0, 0, 0, 0, 1);
        cyc();
        chk("fl0_re_en", {31'd0, ghr_re_en}, 32'd0);
        chk("fl0_recovering", {31'd0, recovering}, 32'd0);
        chk("fl0_count", ckpt_count, 32'd0);

        // Fill all slots.
        for (int i = 0; i < DEPTH; i++) predict(logic'(i % 3 == 0));
        chk("full_count", ckpt_count, 32'd8);
        chk("full_ready", {31'd0, pred_ready}, 32'd0);
        set_in(1, 1, 0, 0, 0, 0);
        #1;
        chk("full_9th_wr_en", {31'd0, ghr_wr_en}, 32'd0);
        cyc();
        chk("full_9th_count", ckpt_count, 32'd8);
        chk("full_9th_ghr", ghr_q, m_ghr);

        // Correct resolve with a predict: pop does not free the slot yet.
        set_in(1, 1, 1, 0, 0, 0);
        #1;
        chk("pop_push_wr_en", {31'd0, ghr_wr_en}, 32'd0);
        void'(ck_q.pop_front());
        cyc();
        chk("pop_count", ckpt_count, 32'd7);
        chk("pop_ready", {31'd0, pred_ready}, 32'd1);
        predict(1'b1);
        chk("refill_count", ckpt_count, 32'd8);

        // Mispredict coincident with a prediction: only the restore.
        set_in(1, 0, 1, 1, 1, 0);
        #1;
        chk("mispred_wr_en", {31'd0, ghr_wr_en}, 32'd0);
        reload_q.push_back({ck_q[0][HIST_W-2:0], 1'b1});
        m_ghr = {ck_q[0][HIST_W-2:0], 1'b1};
        ck_q.delete();
        cyc();
        chk("mispred2_re_en", {31'd0, ghr_re_en}, 32'd1);
        chk("mispred2_count", ckpt_count, 32'd0);
        cyc();
        chk("mispred2_ghr", ghr_q, m_ghr);

        // Resolve while empty: sticky underflow.
        set_in(0, 0, 1, 0, 0, 0);
        cyc();
        chk("uf_err", {31'd0, err_underflow}, 32'd1);
        chk("uf_count", ckpt_count, 32'd0);
        repeat (3) cyc();
        chk("uf_err_held", {31'd0, err_underflow}, 32'd1);

        // Reset asserted during RECOVER.
        predict(1'b0);
        set_in(0, 0, 1, 1, 1, 0);
        ck_q.delete();
        cyc();
        reset = 1'b1;
        #1;
        chk("rr_re_en", {31'd0, ghr_re_en}, 32'd0);
        chk("rr_re_data", ghr_re_data, 32'd0);
        chk("rr_pred_ready", {31'd0, pred_ready}, 32'd0);
        cyc();
        chk("rr_recovering", {31'd0, recovering}, 32'd0);
        chk("rr_count", ckpt_count, 32'd0);
        chk("rr_err", {31'd0, err_underflow}, 32'd0);
        chk("rr_re_en2", {31'd0, ghr_re_en}, 32'd0);
        chk("rr_wr_en", {31'd0, ghr_wr_en}, 32'd0);
        reset = 1'b0;
        m_ghr = 14'h1ABC;
        #1;
        chk("rr_ready_after", {31'd0, pred_ready}, 32'd1);
        chk("rr_ghr", ghr_q, m_ghr);
        cyc();
        chk("rr_idle_re_en", {31'd0, ghr_re_en}, 32'd0);

        chk("reload_drained", reload_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ghr_ckpt_ctrl
`default_nettype wire
